uc_ctrl: RTL
============

UC_CTRL -- requirements
Module: uc_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Opcode  input  6  instruction bits [15:10] from the datapath.
REQ-005 z  input  1  registered zero flag from the datapath.
REQ-006 run  input  1  level; request free-running execution.
REQ-007 step  input  1  level, sampled per cycle; request single-instruction execution.
REQ-008 s_inc  output  1  PC mux select: 1 = PC+1, 0 = jump target instr[9:0].
REQ-009 s_inm  output  1  immediate select for the register-file and ALU muxes.
REQ-010 we3  output  1  register-file write enable.
REQ-011 wez  output  1  zero-flag write enable.
REQ-012 Op  output  3  ALU operation.
REQ-013 pc_en  output  1  PC register load enable; datapath PC SHALL hold when 0.
REQ-014 halted  output  1  registered; 1 in IDLE or HALTED.
REQ-015 illegal  output  1  registered one-cycle pulse after an undefined opcode executes.
REQ-016 retired  output  CNT_W  registered count of executed instructions.

Function
REQ-017 FSM states SHALL be IDLE, RUN, HALTED, STEP; outputs SHALL be decoded combinationally from state, Opcode and z.
REQ-018 "Execute cycle" SHALL mean state RUN or STEP; outside an execute cycle pc_en=0, we3=0, wez=0, s_inc=1, s_inm=0, Op=000.
REQ-019 Decode in an execute cycle: Opcode[5:3]=001 -> ALU reg op, Op=Opcode[2:0], s_inm=0, we3=1, wez=1, s_inc=1, pc_en=1.
REQ-020 Opcode[5:2]=0100 -> load immediate, s_inm=1, Op=000, we3=1, wez=0, s_inc=1, pc_en=1.
REQ-021 010100 J -> s_inc=0, pc_en=1; 010101 JZ -> s_inc=~z; 010110 JNZ -> s_inc=z; no register or flag write.
REQ-022 000000 NOP -> s_inc=1, pc_en=1, no writes.
REQ-023 111111 HALT -> pc_en=0, no writes; next state HALTED; PC stays on the HALT instruction.
REQ-024 Any other opcode SHALL execute as NOP and set illegal=1 for the following cycle only.
REQ-025 Transitions: IDLE/HALTED + run=1 -> RUN; IDLE/HALTED + run=0, step=1 -> STEP; STEP -> HALTED unconditionally after one cycle; RUN + run=0 -> HALTED after completing the current cycle's instruction.
REQ-026 run and step both 1 in IDLE/HALTED SHALL give RUN (run has priority).
REQ-027 HALTED + run=1 while Opcode=HALT SHALL enter RUN, re-execute HALT and return to HALTED (no livelock beyond one cycle per attempt).
REQ-028 retired SHALL increment by 1 on every execute cycle with pc_en=1 and SHALL saturate at all-ones without wrapping.
REQ-029 halted SHALL be 1 the cycle after entering IDLE or HALTED and 0 the cycle after entering RUN or STEP.

Reset
REQ-030 reset SHALL asynchronously force state IDLE, halted=1, illegal=0, retired=0.
REQ-031 While reset=1 all combinational controls SHALL take the non-execute values from REQ-018; reset mid-instruction SHALL abort it with no register or flag write.
REQ-032 After reset deassertion, no instruction SHALL execute until run or step is asserted.

Configuration
REQ-033 Macro UC_CTRL_STEP_EN defined: STEP state and step input behave as specified.
REQ-034 Macro UC_CTRL_STEP_EN undefined: STEP state SHALL be absent, step SHALL be ignored, and only run leaves IDLE/HALTED; port list unchanged.

Verification
REQ-035 Reset, run=0 for 10 cycles -> pc_en=0, we3=0, halted=1, retired=0 throughout.
REQ-036 run=1, Opcode=001010 -> Op=010, we3=1, wez=1, s_inc=1, pc_en=1; retired 0->1 next edge.
REQ-037 RUN, Opcode=010101 with z=1 -> s_inc=0; with z=0 -> s_inc=1; we3=0, wez=0 in both.
REQ-038 RUN, Opcode=111111 -> pc_en=0 that cycle, halted=1 next cycle; then run=0, step=1 for one cycle with Opcode=010000 -> exactly one cycle with we3=1, s_inm=1, then HALTED (step disabled build: no execution).
REQ-039 RUN, Opcode=101010 -> illegal=1 for exactly one cycle, pc_en=1, we3=0; retired with CNT_W=4 driven to 15 holds at 15.
REQ-040 reset asserted mid-RUN between edges -> we3=0, pc_en=0 immediately, state IDLE, retired=0.

Source files
------------

// File: rtl/uc_ctrl.sv
// Microcoded-CPU control unit: run/halt/step FSM, instruction decode, retired-instruction counter.
// Optional single-step support is enabled by defining UC_CTRL_STEP_EN.
module uc_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    input  logic             run,
    input  logic             step,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             pc_en,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

`ifdef UC_CTRL_STEP_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_STEP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;
`endif

    localparam logic [5:0] OPC_HALT = 6'b111111;

    state_t           r_state;
    logic             r_halted;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    logic w_exec;
    logic w_undef;
    logic w_halt_op;
    logic w_step_req;

    assign w_halt_op = (Opcode == OPC_HALT);

`ifdef UC_CTRL_STEP_EN
    assign w_exec     = ((r_state == S_RUN) || (r_state == S_STEP)) && !reset;
    assign w_step_req = step;
`else
    assign w_exec     = (r_state == S_RUN) && !reset;
    // Without single-step support the step request is deliberately discarded.
    assign w_step_req = 1'b0 & step;
`endif

    // Instruction decode; non-execute cycles and reset get the safe defaults.
    always_comb begin
        pc_en   = 1'b0;
        we3     = 1'b0;
        wez     = 1'b0;
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        Op      = 3'b000;
        w_undef = 1'b0;
        if (w_exec) begin
            pc_en = 1'b1;
            casez (Opcode)
                6'b001???: begin
                    Op  = Opcode[2:0];
                    we3 = 1'b1;
                    wez = 1'b1;
                end
                6'b0100??: begin
                    s_inm = 1'b1;
                    we3   = 1'b1;
                end
                6'b010100: s_inc = 1'b0;
                6'b010101: s_inc = ~z;
                6'b010110: s_inc = z;
                6'b000000: ;
                6'b111111: pc_en = 1'b0;
                default:   w_undef = 1'b1;
            endcase
        end
    end

    // Control FSM with registered status outputs and saturating retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_halted  <= 1'b1;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_illegal <= w_exec & w_undef;
            if (w_exec && pc_en && !(&r_retired)) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (run) begin
                        r_state  <= S_RUN;
                        r_halted <= 1'b0;
                    end else if (w_step_req) begin
`ifdef UC_CTRL_STEP_EN
                        r_state  <= S_STEP;
                        r_halted <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    // HALT wins even with run held, so a HALT loop costs one cycle per attempt.
                    if (w_halt_op || !run) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end
                end
`ifdef UC_CTRL_STEP_EN
                S_STEP: begin
                    r_state  <= S_HALTED;
                    r_halted <= 1'b1;
                end
`endif
                default: begin
                    r_state  <= S_IDLE;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    assign halted  = r_halted;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule
